// File: rtl/rf_access_arbiter_pkg.sv
// rtl/rf_access_arbiter_pkg.sv - shared defaults and index helpers for the register-file arbiter
package rf_access_arbiter_pkg;

   localparam int DEF_WORD_SIZE = 16;
   localparam int DEF_ADDR_SIZE = 3;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // Modular add keeps round-robin indices legal for non-power-of-two requester counts.
   function automatic int wrap_add(input int a, input int b, input int n);
      return (a + b) % n;
   endfunction

   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/rf_access_arbiter_rr_pick.sv
// rtl/rf_access_arbiter_rr_pick.sv - combinational round-robin finder over a masked request vector
module rf_access_arbiter_rr_pick
   import rf_access_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   start_i,
   input  logic [NUM_REQ-1:0] mask_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0]   idx_o,
   output logic               found_o
);

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found_o = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found_o && req_i[wrap_add(int'(start_i), k, NUM_REQ)]
                      && mask_i[wrap_add(int'(start_i), k, NUM_REQ)]) begin
            found_o = 1'b1;
            gnt_o[wrap_add(int'(start_i), k, NUM_REQ)] = 1'b1;
            idx_o   = PTR_W'(wrap_add(int'(start_i), k, NUM_REQ));
         end
      end
   end

endmodule

// File: rtl/rf_access_arbiter.sv
// rtl/rf_access_arbiter.sv - round-robin sharing of one 1W/2R register file among requesters
module rf_access_arbiter
   import rf_access_arbiter_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int ADDR_SIZE = DEF_ADDR_SIZE,
   parameter int NUM_REQ   = 4,
   parameter int PTR_W     = clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             wr_req,
   input  logic [NUM_REQ*ADDR_SIZE-1:0]   wr_addr,
   input  logic [NUM_REQ*WORD_SIZE-1:0]   wr_data,
   output logic [NUM_REQ-1:0]             wr_gnt,
   input  logic [NUM_REQ-1:0]             rd_req,
   input  logic [NUM_REQ*ADDR_SIZE-1:0]   rd_addr,
   output logic [NUM_REQ-1:0]             rd_gnt,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [NUM_REQ*WORD_SIZE-1:0]   rsp_data,
   output logic                           rf_wrtEnable,
   output logic [ADDR_SIZE-1:0]           rf_wrtAddr,
   output logic [WORD_SIZE-1:0]           rf_wrtData,
   output logic [ADDR_SIZE-1:0]           rf_rdAddr1,
   output logic [ADDR_SIZE-1:0]           rf_rdAddr2,
   input  logic [WORD_SIZE-1:0]           rf_rdData1,
   input  logic [WORD_SIZE-1:0]           rf_rdData2
);

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic               p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d;
   logic [PTR_W-1:0]   p1_id_q, p1_id_d, p2_id_q, p2_id_d;
   logic [NUM_REQ-1:0] wr_req_m, rd_req_m;
   logic [NUM_REQ-1:0] p1_gnt, p2_gnt;
   logic [PTR_W-1:0]   w_idx, p1_idx, p2_idx;
   logic               w_found, p1_found, p2_found;

   // Reset blanks the requests, so no grant or register-file write can leak out while rst is high.
   assign wr_req_m = rst ? '0 : wr_req;
   assign rd_req_m = rst ? '0 : rd_req;

   rf_access_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_wr_pick (
      .req_i(wr_req_m), .start_i(wr_ptr_q), .mask_i({NUM_REQ{1'b1}}),
      .gnt_o(wr_gnt), .idx_o(w_idx), .found_o(w_found)
   );

   rf_access_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rd1_pick (
      .req_i(rd_req_m), .start_i(rd_ptr_q), .mask_i({NUM_REQ{1'b1}}),
      .gnt_o(p1_gnt), .idx_o(p1_idx), .found_o(p1_found)
   );

   // Port 2 continues the same scan with the port-1 winner removed.
   rf_access_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rd2_pick (
      .req_i(rd_req_m), .start_i(rd_ptr_q), .mask_i(~p1_gnt),
      .gnt_o(p2_gnt), .idx_o(p2_idx), .found_o(p2_found)
   );

   assign rd_gnt = p1_gnt | p2_gnt;

   always_comb begin
      rf_wrtEnable = w_found;
      rf_wrtAddr   = '0;
      rf_wrtData   = '0;
      rf_rdAddr1   = '0;
      rf_rdAddr2   = '0;
      if (w_found) begin
         rf_wrtAddr = wr_addr[slice_lo(int'(w_idx), ADDR_SIZE) +: ADDR_SIZE];
         rf_wrtData = wr_data[slice_lo(int'(w_idx), WORD_SIZE) +: WORD_SIZE];
      end
      if (p1_found) rf_rdAddr1 = rd_addr[slice_lo(int'(p1_idx), ADDR_SIZE) +: ADDR_SIZE];
      if (p2_found) rf_rdAddr2 = rd_addr[slice_lo(int'(p2_idx), ADDR_SIZE) +: ADDR_SIZE];
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (w_found) wr_ptr_d = PTR_W'(wrap_add(int'(w_idx), 1, NUM_REQ));
      if (p2_found)      rd_ptr_d = PTR_W'(wrap_add(int'(p2_idx), 1, NUM_REQ));
      else if (p1_found) rd_ptr_d = PTR_W'(wrap_add(int'(p1_idx), 1, NUM_REQ));
      p1_vld_d = p1_found;
      p1_id_d  = p1_idx;
      p2_vld_d = p2_found;
      p2_id_d  = p2_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         p1_vld_q <= 1'b0;
         p1_id_q  <= '0;
         p2_vld_q <= 1'b0;
         p2_id_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         p1_vld_q <= p1_vld_d;
         p1_id_q  <= p1_id_d;
         p2_vld_q <= p2_vld_d;
         p2_id_q  <= p2_id_d;
      end
   end

   // Register-file read data is already registered, so routing it back is purely combinational.
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      if (p1_vld_q) begin
         rsp_valid[p1_id_q] = 1'b1;
         rsp_data[slice_lo(int'(p1_id_q), WORD_SIZE) +: WORD_SIZE] = rf_rdData1;
      end
      if (p2_vld_q) begin
         rsp_valid[p2_id_q] = 1'b1;
         rsp_data[slice_lo(int'(p2_id_q), WORD_SIZE) +: WORD_SIZE] = rf_rdData2;
      end
   end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// tb/tb_rf_access_arbiter.sv - scoreboard bench for rf_access_arbiter with a behavioural register file
module tb_rf_access_arbiter;

   localparam int NR = 4;
   localparam int WS = 16;
   localparam int AS = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     wr_req = '0;
   logic [NR*AS-1:0]  wr_addr = '0;
   logic [NR*WS-1:0]  wr_data = '0;
   logic [NR-1:0]     wr_gnt;
   logic [NR-1:0]     rd_req = '0;
   logic [NR*AS-1:0]  rd_addr = '0;
   logic [NR-1:0]     rd_gnt;
   logic [NR-1:0]     rsp_valid;
   logic [NR*WS-1:0]  rsp_data;
   logic              rf_wrtEnable;
   logic [AS-1:0]     rf_wrtAddr;
   logic [WS-1:0]     rf_wrtData;
   logic [AS-1:0]     rf_rdAddr1;
   logic [AS-1:0]     rf_rdAddr2;
   logic [WS-1:0]     rf_rdData1 = '0;
   logic [WS-1:0]     rf_rdData2 = '0;

   rf_access_arbiter #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .NUM_REQ(NR), .PTR_W(2)) dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rf_wrtEnable(rf_wrtEnable), .rf_wrtAddr(rf_wrtAddr), .rf_wrtData(rf_wrtData),
      .rf_rdAddr1(rf_rdAddr1), .rf_rdAddr2(rf_rdAddr2),
      .rf_rdData1(rf_rdData1), .rf_rdData2(rf_rdData2)
   );

   always #5 clk = ~clk;

   // Register file with registered reads: a same-edge write is not visible to the read.
   logic [WS-1:0] rf_mem [8];
   initial for (int i = 0; i < 8; i++) rf_mem[i] = '0;
   always @(posedge clk) begin
      rf_rdData1 <= rf_mem[rf_rdAddr1];
      rf_rdData2 <= rf_mem[rf_rdAddr2];
      if (rf_wrtEnable) rf_mem[rf_wrtAddr] <= rf_wrtData;
   end

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model state: pending requests, pointers, register contents.
   bit            wp [NR];
   logic [AS-1:0] wa [NR];
   logic [WS-1:0] wd [NR];
   bit            rp [NR];
   logic [AS-1:0] ra [NR];
   int            wptr_m = 0;
   int            rptr_m = 0;
   logic [WS-1:0] mem_m [8];
   bit            auto_fill = 0;
   logic [NR-1:0] obs_wr_gnt, obs_rd_gnt;

   typedef struct {
      int            cyc;
      logic [WS-1:0] data;
   } exp_t;
   exp_t exp_q [NR][$];

   function automatic int rr_first(input bit r [NR], input int start, input int excl);
      for (int k = 0; k < NR; k++) begin
         int j;
         j = (start + k) % NR;
         if (r[j] && j != excl) return j;
      end
      return -1;
   endfunction

   task automatic step(input bit do_rst);
      int w, r1, r2;
      logic [NR-1:0] ew, er;
      exp_t e;
      if (auto_fill) begin
         for (int i = 0; i < NR; i++) begin
            if (!wp[i] && $urandom_range(0, 99) < 55) begin
               wp[i] = 1; wa[i] = AS'($urandom_range(0, 7)); wd[i] = WS'($urandom);
            end
            if (!rp[i] && $urandom_range(0, 99) < 65) begin
               rp[i] = 1; ra[i] = AS'($urandom_range(0, 7));
            end
         end
      end
      @(negedge clk);
      rst = do_rst;
      for (int i = 0; i < NR; i++) begin
         wr_req[i] = wp[i];
         wr_addr[i*AS +: AS] = wa[i];
         wr_data[i*WS +: WS] = wd[i];
         rd_req[i] = rp[i];
         rd_addr[i*AS +: AS] = ra[i];
      end
      #1;
      w = -1; r1 = -1; r2 = -1;
      if (!do_rst) begin
         w  = rr_first(wp, wptr_m, -1);
         r1 = rr_first(rp, rptr_m, -1);
         if (r1 >= 0) r2 = rr_first(rp, rptr_m, r1);
      end
      ew = '0; er = '0;
      if (w >= 0)  ew[w]  = 1'b1;
      if (r1 >= 0) er[r1] = 1'b1;
      if (r2 >= 0) er[r2] = 1'b1;
      check("wr_gnt", wr_gnt, ew);
      check("rd_gnt", rd_gnt, er);
      check("rf_wrtEnable", rf_wrtEnable, (w >= 0));
      check("rf_wrtAddr", rf_wrtAddr, (w >= 0) ? wa[w] : '0);
      check("rf_wrtData", rf_wrtData, (w >= 0) ? wd[w] : '0);
      check("rf_rdAddr1", rf_rdAddr1, (r1 >= 0) ? ra[r1] : '0);
      check("rf_rdAddr2", rf_rdAddr2, (r2 >= 0) ? ra[r2] : '0);
      obs_wr_gnt = wr_gnt;
      obs_rd_gnt = rd_gnt;
      if (r1 >= 0) begin
         e.cyc = cyc_cnt + 1; e.data = mem_m[ra[r1]]; exp_q[r1].push_back(e); rp[r1] = 0;
      end
      if (r2 >= 0) begin
         e.cyc = cyc_cnt + 1; e.data = mem_m[ra[r2]]; exp_q[r2].push_back(e); rp[r2] = 0;
      end
      if (w >= 0) begin
         mem_m[wa[w]] = wd[w]; wp[w] = 0;
      end
      if (do_rst) begin
         wptr_m = 0; rptr_m = 0;
      end else begin
         if (w >= 0) wptr_m = (w + 1) % NR;
         if (r2 >= 0)      rptr_m = (r2 + 1) % NR;
         else if (r1 >= 0) rptr_m = (r1 + 1) % NR;
      end
   endtask

   // Monitor: each cycle, compare every response slice with the scoreboard head.
   always @(posedge clk) begin
      #3;
      for (int i = 0; i < NR; i++) begin
         bit   exp_v;
         exp_t e;
         exp_v = (exp_q[i].size() > 0) && (exp_q[i][0].cyc == cyc_cnt);
         check($sformatf("rsp_valid[%0d]", i), rsp_valid[i], exp_v);
         if (exp_v) begin
            e = exp_q[i].pop_front();
            check($sformatf("rsp_data[%0d]", i), rsp_data[i*WS +: WS], e.data);
         end else begin
            check($sformatf("rsp_data_idle[%0d]", i), rsp_data[i*WS +: WS], '0);
         end
         while (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc_cnt) void'(exp_q[i].pop_front());
      end
   end

   initial begin
      for (int i = 0; i < 8; i++) mem_m[i] = '0;
      for (int i = 0; i < NR; i++) begin
         wp[i] = 0; rp[i] = 0; wa[i] = '0; wd[i] = '0; ra[i] = '0;
      end

      step(1); step(1);
      step(0);
      @(posedge clk); #3;
      check("reset_rsp_valid", rsp_valid, '0);
      check("reset_rsp_data_lo", rsp_data[31:0], '0);
      check("reset_rsp_data_hi", rsp_data[63:32], '0);

      // Write contention: everyone writes its own index.
      for (int i = 0; i < NR; i++) begin
         wp[i] = 1; wa[i] = AS'(i); wd[i] = 16'hA000 | WS'(i << 4);
      end
      for (int i = 0; i < NR; i++) begin
         logic [NR-1:0] g;
         step(0);
         g = '0; g[i] = 1'b1;
         check("contention_wr_gnt", obs_wr_gnt, g);
      end

      // Dual read of the freshly written registers.
      rp[1] = 1; ra[1] = 3'd3; rp[2] = 1; ra[2] = 3'd1;
      step(0);
      check("dual_rd_gnt", obs_rd_gnt, 4'b0110);
      @(posedge clk); #3;
      check("dual_rsp_valid", rsp_valid, 4'b0110);
      check("dual_rsp_data1", rsp_data[1*WS +: WS], 16'hA030);
      check("dual_rsp_data2", rsp_data[2*WS +: WS], 16'hA010);

      // Bring rd_ptr back to 0, then all four read continuously.
      rp[3] = 1; ra[3] = 3'd0;
      step(0);
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < NR; i++) begin rp[i] = 1; ra[i] = AS'(i); end
         step(0);
         check("fair_rd_gnt", obs_rd_gnt, (c % 2 == 0) ? 4'b0011 : 4'b1100);
      end
      for (int i = 0; i < NR; i++) rp[i] = 0;

      // Same-cycle hazard on address 5.
      wp[0] = 1; wa[0] = 3'd5; wd[0] = 16'h1234;
      rp[1] = 1; ra[1] = 3'd5;
      step(0);
      @(posedge clk); #3;
      check("hazard_old", rsp_data[1*WS +: WS], 16'h0000);
      rp[1] = 1; ra[1] = 3'd5;
      step(0);
      @(posedge clk); #3;
      check("hazard_new", rsp_data[1*WS +: WS], 16'h1234);

      // Requester 3 streams writes and reads alone.
      for (int c = 0; c < 8; c++) begin
         wp[3] = 1; wa[3] = AS'(c); wd[3] = WS'(16'h3000 + c);
         rp[3] = 1; ra[3] = AS'(7 - c);
         step(0);
         check("stream_wr_gnt", obs_wr_gnt, 4'b1000);
         check("stream_rd_gnt", obs_rd_gnt, 4'b1000);
      end

      // Reset mid-burst: the response granted before reset still lands, nothing after.
      for (int i = 0; i < NR; i++) begin rp[i] = 1; ra[i] = AS'(i + 2); end
      step(0);
      step(1);
      check("rst_wr_gnt", obs_wr_gnt, '0);
      check("rst_rd_gnt", obs_rd_gnt, '0);
      @(posedge clk); #3;
      check("rst_discard_rsp", rsp_valid, '0);

      auto_fill = 1;
      for (int c = 0; c < 400; c++) step($urandom_range(0, 59) == 0);
      auto_fill = 0;
      for (int i = 0; i < NR; i++) begin wp[i] = 0; rp[i] = 0; end
      for (int c = 0; c < 4; c++) step(0);
      @(posedge clk); #4;
      for (int i = 0; i < NR; i++) check($sformatf("drain[%0d]", i), exp_q[i].size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
